reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, 64, register width in bits.
REQ-002 Parameter DEPTH, 32, number of registers, 2..256, power of two not required.
REQ-003 Parameter N_RD, 2, number of read ports, 1..4.
REQ-004 Parameter ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.
REQ-005 Derived constant ADDR_W = clog2(DEPTH), minimum 1.
REQ-006 Port clk, input, 1, single clock, all state updates on rising edge.
REQ-007 Port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-008 Port rd_addr, input, N_RD*ADDR_W, packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 Port rd_data, output, N_RD*DATA_W, packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-010 Port wr_en, input, 2, write enables for write ports 0 and 1.
REQ-011 Port wr_addr, input, 2*ADDR_W, packed write addresses.
REQ-012 Port wr_data, input, 2*DATA_W, packed write data.
REQ-013 Port init_busy, output, 1, high while the clear sequence runs; access is ignored or zeroed.

Function
REQ-014 The FSM SHALL have two states: CLEAR and READY.
REQ-015 In CLEAR with rst low, each cycle SHALL write zero to mem[idx] and increment idx; at idx==DEPTH-1 it SHALL move to READY.
REQ-016 init_busy SHALL be 1 in CLEAR and 0 in READY, so it stays high for exactly DEPTH cycles after rst falls.
REQ-017 In CLEAR, wr_en SHALL be ignored and every rd_data lane SHALL read zero.
REQ-018 In READY, wr_en[p]=1 SHALL write wr_data lane p to mem[wr_addr lane p] at the clock edge.
REQ-019 When both write ports target the same address in one cycle, port 1 SHALL win.
REQ-020 Writes to address >= DEPTH SHALL be dropped; reads of address >= DEPTH SHALL return zero.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be dropped and reads of address 0 SHALL return zero, including via bypass.
REQ-022 Reads SHALL be combinational, with zero latency from rd_addr to rd_data.
REQ-023 Reads SHALL be write-first: if an enabled write in the same cycle targets the read address, rd_data SHALL return that write data, with port 1 taking priority over port 0.
REQ-024 Read ports SHALL be independent; any number may address the same register.

Reset
REQ-025 When rst is sampled high, the next state SHALL be CLEAR with idx=0, and writes that cycle SHALL be ignored.
REQ-026 rst asserted during CLEAR SHALL restart the sequence at idx 0.
REQ-027 rst asserted in READY SHALL discard all contents through the full clear sequence.
REQ-028 Reset values SHALL be: init_busy=1 and rd_data=0 on all lanes; after the sequence every register SHALL be 0.
REQ-029 Power-up without rst is undefined; the bench SHALL always apply rst first.

Structure
REQ-030 A shared package reg_file_pkg SHALL hold the state enum (CLEAR, READY) and the default DATA_W, DEPTH and N_RD constants.
REQ-031 One sub-module, reg_file_rd_mux, SHALL implement a single read lane (range check, zero-reg, bypass priority) and be instantiated N_RD times by generate.
REQ-032 Storage SHALL be a plain array with no per-entry reset, so the design stays mappable to distributed RAM.

Verification
REQ-033 Clear timing: rst high for 1 cycle -> init_busy=1 for exactly 32 cycles; then all 32 addresses read 0.
REQ-034 Basic write/read: write port 0 writes 64'h1 to addr 1 -> next cycle rd_addr lane0=1 reads 64'h1; with wr_en=0 the value is held.
REQ-035 Zero register: write 64'hFFFF to addr 0 -> rd_data at addr 0 = 0, both in the same cycle (bypass) and the next cycle.
REQ-036 Write collision and bypass: both ports write addr 5 (port0 64'hA, port1 64'hB) while lane1 reads addr 5 -> same-cycle read = 64'hB, next cycle = 64'hB.
REQ-037 Reset mid-clear: assert rst at clear cycle 10 -> init_busy stays high for another 32 cycles after rst falls; a write attempted during clear is lost.
REQ-038 Non-power-of-two depth: with DEPTH=20, write 64'h7 to addr 25 -> dropped; addr 25 reads 0 and addr 9 (25 mod 16) is unchanged.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
// The state enum is shared so the top and any bench agree on the FSM encoding.
package reg_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_N_RD   = 2;

endpackage

// File: rtl/reg_file_rd_mux.sv
// One read lane: returns the stored word or the same-cycle write data (port 1 first),
// zeroed while clearing, for out-of-range addresses and for the hardwired zero register.
module reg_file_rd_mux
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                busy,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic [1:0]          wr_en,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]   rd_data
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic in_range;
  logic is_zero;

  assign in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign is_zero  = (ZERO_REG != 0) && (rd_addr == '0);

  // wr_en arrives already qualified, so a matching enable means the write really happens.
  always_comb begin
    rd_data = mem_data;
    if (wr_en[0] && (wr_addr[0 +: ADDR_W] == rd_addr)) begin
      rd_data = wr_data[0 +: DATA_W];
    end
    if (wr_en[1] && (wr_addr[ADDR_W +: ADDR_W] == rd_addr)) begin
      rd_data = wr_data[DATA_W +: DATA_W];
    end
    if (busy || !in_range || is_zero) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 write ports, N_RD combinational write-first read ports,
// and a one-entry-per-cycle clear sequence after reset instead of a per-entry reset.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int N_RD     = DEF_N_RD,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  output logic                     init_busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clear_we;
  logic [1:0]        wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clear_we = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_we = 1'b1;
        idx_d    = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = READY;
          idx_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  assign init_busy = (state_q == CLEAR);

  // Qualified write enables are shared with the read lanes so bypass never shows a dropped write.
  for (genvar p = 0; p < 2; p++) begin : g_wr
    logic [ADDR_W-1:0] addr;
    assign addr     = wr_addr[p*ADDR_W +: ADDR_W];
    assign wr_ok[p] = wr_en[p] && (state_q == READY) && !rst
                      && ({1'b0, addr} < DEPTH_W)
                      && !((ZERO_REG != 0) && (addr == '0));
  end

  // No reset on the array itself; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[idx_q] <= '0;
    end else begin
      if (wr_ok[0]) mem[wr_addr[0 +: ADDR_W]] <= wr_data[0 +: DATA_W];
      if (wr_ok[1]) mem[wr_addr[ADDR_W +: ADDR_W]] <= wr_data[DATA_W +: DATA_W];
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_word;
    assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
    assign mem_word = mem[addr];

    reg_file_rd_mux #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_mux (
      .busy     (init_busy),
      .rd_addr  (addr),
      .mem_data (mem_word),
      .wr_en    (wr_ok),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default 32-deep instance plus a 20-deep instance
// for the out-of-range address behaviour, both sharing clock and reset.
module tb_reg_file_mp;

  logic         clk;
  logic         rst;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         init_busy;

  logic [9:0]   rd_addr_b;
  logic [127:0] rd_data_b;
  logic [1:0]   wr_en_b;
  logic [9:0]   wr_addr_b;
  logic [127:0] wr_data_b;
  logic         init_busy_b;

  int vectors;
  int miscompares;

  reg_file_mp u_dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_busy (init_busy)
  );

  reg_file_mp #(.DEPTH(20)) u_dut20 (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr_b),
    .rd_data   (rd_data_b),
    .wr_en     (wr_en_b),
    .wr_addr   (wr_addr_b),
    .wr_data   (wr_data_b),
    .init_busy (init_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en     = 2'b00;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;
    wr_en_b   = 2'b00;
    wr_addr_b = '0;
    wr_data_b = '0;
    rd_addr_b = '0;
  endtask

  task automatic test_reset;
    int cnt;
    int cnt_b;
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (init_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_busy got %b expected 1", init_busy);
    end
    // write attempts throughout the clear must be invisible and ignored
    wr_en   = 2'b11;
    wr_addr = {5'd3, 5'd3};
    wr_data = {64'h55, 64'h44};
    rd_addr = {5'd3, 5'd3};
    cnt   = 0;
    cnt_b = 0;
    while (init_busy && cnt < 100) begin
      #1;
      vectors++;
      if (rd_data !== 128'h0) begin
        miscompares++;
        $display("[TB] FAIL clear_read cycle %0d got %h expected 0", cnt, rd_data);
      end
      if (init_busy_b) cnt_b++;
      tick();
      cnt++;
    end
    idle();
    vectors++;
    if (cnt !== 32) begin
      miscompares++;
      $display("[TB] FAIL clear_len32 got %0d expected 32", cnt);
    end
    vectors++;
    if (cnt_b !== 20) begin
      miscompares++;
      $display("[TB] FAIL clear_len20 got %0d expected 20", cnt_b);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      vectors++;
      if (rd_data !== 128'h0) begin
        miscompares++;
        $display("[TB] FAIL cleared_addr %0d got %h expected 0", a, rd_data);
      end
    end
    for (int a = 0; a < 20; a++) begin
      rd_addr_b = {5'd0, 5'(a)};
      #1;
      vectors++;
      if (rd_data_b[63:0] !== 64'h0) begin
        miscompares++;
        $display("[TB] FAIL cleared_addr20 %0d got %h expected 0", a, rd_data_b[63:0]);
      end
    end
    idle();
  endtask

  task automatic test_basic;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd1};
    wr_data = {64'h0, 64'h1};
    rd_addr = {5'd1, 5'd1};
    #1;
    vectors++;
    if (rd_data !== {64'h1, 64'h1}) begin
      miscompares++;
      $display("[TB] FAIL basic_bypass got %h expected both lanes 1", rd_data);
    end
    tick();
    wr_en = 2'b00;
    #1;
    vectors++;
    if (rd_data !== {64'h1, 64'h1}) begin
      miscompares++;
      $display("[TB] FAIL basic_read got %h expected both lanes 1", rd_data);
    end
    tick();
    vectors++;
    if (rd_data[63:0] !== 64'h1) begin
      miscompares++;
      $display("[TB] FAIL basic_hold got %h expected 1", rd_data[63:0]);
    end
    idle();
  endtask

  task automatic test_zero_reg;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {64'h0, 64'hFFFF};
    rd_addr = {5'd0, 5'd0};
    #1;
    vectors++;
    if (rd_data[63:0] !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL zero_bypass got %h expected 0", rd_data[63:0]);
    end
    tick();
    wr_en = 2'b00;
    #1;
    vectors++;
    if (rd_data[63:0] !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL zero_read got %h expected 0", rd_data[63:0]);
    end
    idle();
  endtask

  task automatic test_collision;
    wr_en   = 2'b11;
    wr_addr = {5'd5, 5'd5};
    wr_data = {64'hB, 64'hA};
    rd_addr = {5'd5, 5'd5};
    #1;
    vectors++;
    if (rd_data !== {64'hB, 64'hB}) begin
      miscompares++;
      $display("[TB] FAIL collide_bypass got %h expected both lanes B", rd_data);
    end
    tick();
    wr_en = 2'b00;
    #1;
    vectors++;
    if (rd_data[127:64] !== 64'hB) begin
      miscompares++;
      $display("[TB] FAIL collide_read got %h expected B", rd_data[127:64]);
    end
    // independent addresses on the two write ports, each bypassed to its own lane
    wr_en   = 2'b11;
    wr_addr = {5'd8, 5'd7};
    wr_data = {64'hD, 64'hC};
    rd_addr = {5'd8, 5'd7};
    #1;
    vectors++;
    if (rd_data !== {64'hD, 64'hC}) begin
      miscompares++;
      $display("[TB] FAIL split_bypass got %h expected D and C", rd_data);
    end
    tick();
    wr_en   = 2'b00;
    rd_addr = {5'd7, 5'd8};
    #1;
    vectors++;
    if (rd_data !== {64'hC, 64'hD}) begin
      miscompares++;
      $display("[TB] FAIL split_read got %h expected C and D", rd_data);
    end
    idle();
  endtask

  task automatic test_out_of_range;
    wr_en_b   = 2'b01;
    wr_addr_b = {5'd0, 5'd9};
    wr_data_b = {64'h0, 64'h99};
    tick();
    wr_en_b   = 2'b01;
    wr_addr_b = {5'd0, 5'd25};
    wr_data_b = {64'h0, 64'h7};
    rd_addr_b = {5'd9, 5'd25};
    #1;
    vectors++;
    if (rd_data_b !== {64'h99, 64'h0}) begin
      miscompares++;
      $display("[TB] FAIL oor_bypass got %h expected 99 and 0", rd_data_b);
    end
    tick();
    wr_en_b = 2'b00;
    #1;
    vectors++;
    if (rd_data_b !== {64'h99, 64'h0}) begin
      miscompares++;
      $display("[TB] FAIL oor_read got %h expected 99 and 0", rd_data_b);
    end
    idle();
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    // reset from READY: the write in the reset cycle must not bypass
    rst     = 1'b1;
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {64'h0, 64'h33};
    rd_addr = {5'd0, 5'd3};
    #1;
    vectors++;
    if (rd_data[63:0] !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_cycle_bypass got %h expected 0", rd_data[63:0]);
    end
    tick();
    rst = 1'b0;
    idle();
    repeat (10) tick();
    vectors++;
    if (init_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midclear_busy got %b expected 1", init_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (init_busy && cnt < 100) begin
      if (cnt == 20) begin
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd2};
        wr_data = {64'h0, 64'h1234};
        rd_addr = {5'd0, 5'd2};
        #1;
        vectors++;
        if (rd_data[63:0] !== 64'h0) begin
          miscompares++;
          $display("[TB] FAIL clear_write_bypass got %h expected 0", rd_data[63:0]);
        end
      end else begin
        wr_en = 2'b00;
      end
      tick();
      cnt++;
    end
    idle();
    vectors++;
    if (cnt !== 32) begin
      miscompares++;
      $display("[TB] FAIL restart_len got %0d expected 32", cnt);
    end
    rd_addr = {5'd1, 5'd2};
    #1;
    vectors++;
    if (rd_data !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL lost_write got %h expected 0", rd_data);
    end
    rd_addr = {5'd7, 5'd5};
    #1;
    vectors++;
    if (rd_data !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL discarded got %h expected 0", rd_data);
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle();
    $display("[TB] start");
    test_reset();
    test_basic();
    test_zero_reg();
    test_collision();
    test_out_of_range();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
